eth_pkt_fifo: RTL

Store-and-forward packet FIFO on the 10G datapath, in the clk156 domain. It sits between a MAC RX AXI-Stream master and a MAC TX AXI-Stream slave, for example the port-1 forwarding path from the nonshared MAC's RX back to its TX.
- Buffers whole frames and releases a frame only after its tlast has been accepted with tuser=0.
- Drops errored frames (tuser=1) and frames that overflow the buffer.
- The MAC RX has no tready, so the block never backpressures its input.

---
 rtl/eth_pkg.sv | 12 +
 rtl/eth_pkt_fifo_ram.sv | 23 ++
 rtl/eth_pkt_fifo.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared widths and write-FSM encodings for the packet FIFO
package eth_pkg;
   localparam int AXIS_DATA_W = 64;
   localparam int AXIS_KEEP_W = 8;
   localparam int FIFO_WORD_W = AXIS_DATA_W + AXIS_KEEP_W + 1;

   typedef enum logic [1:0] {
      WR_IDLE  = 2'd0,
      WR_WRITE = 2'd1,
      WR_DROP  = 2'd2
   } wr_state_e;
endpackage

// File: rtl/eth_pkt_fifo_ram.sv
// rtl/eth_pkt_fifo_ram.sv - simple dual-port RAM with a registered read port
module eth_pkt_fifo_ram #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 73
) (
   input  logic              clk156,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   // rd_data holds its value between reads; the top uses it as a one-word skid slot
   always_ff @(posedge clk156) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
      if (rd_en)
         rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/eth_pkt_fifo.sv
// rtl/eth_pkt_fifo.sv - store-and-forward packet FIFO, drops errored and overflowing frames
module eth_pkt_fifo
   import eth_pkg::*;
#(
   parameter int DEPTH_LOG2 = 9,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                   clk156,
   input  logic                   eth_rst_n,
   input  logic                   s_axis_tvalid,
   input  logic [AXIS_DATA_W-1:0] s_axis_tdata,
   input  logic [AXIS_KEEP_W-1:0] s_axis_tkeep,
   input  logic                   s_axis_tlast,
   input  logic                   s_axis_tuser,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic [AXIS_DATA_W-1:0] m_axis_tdata,
   output logic [AXIS_KEEP_W-1:0] m_axis_tkeep,
   output logic                   m_axis_tlast,
   output logic                   m_axis_tuser,
   output logic [CNT_WIDTH-1:0]   pkt_fwd_cnt,
   output logic [CNT_WIDTH-1:0]   drop_err_cnt,
   output logic [CNT_WIDTH-1:0]   drop_ovf_cnt,
   output logic [DEPTH_LOG2:0]    fifo_level
);
   localparam int PW = DEPTH_LOG2 + 1;
   localparam logic [PW-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [1:0] rst_sync;
   logic       rst_n;

   always_ff @(posedge clk156 or negedge eth_rst_n) begin
      if (!eth_rst_n)
         rst_sync <= 2'b00;
      else
         rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   wr_state_e            state, state_nxt;
   logic [PW-1:0]        wr_ptr, wr_ptr_nxt, wr_commit, wr_commit_nxt;
   logic [PW-1:0]        rd_ptr, fetch_ptr;
   logic                 full, ram_we, inc_fwd, inc_err, inc_ovf;
   logic                 readable, consume, fetch, q_valid;
   logic [FIFO_WORD_W-1:0] ram_q;

   // rd_ptr advances on consumption, so words in the output stage still occupy space
   assign full = (wr_ptr - rd_ptr) == DEPTH;

   always_ff @(posedge clk156 or negedge rst_n) begin
      if (!rst_n)
         state <= WR_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      wr_ptr_nxt    = wr_ptr;
      wr_commit_nxt = wr_commit;
      ram_we        = 1'b0;
      inc_fwd       = 1'b0;
      inc_err       = 1'b0;
      inc_ovf       = 1'b0;
      if (s_axis_tvalid) begin
         unique case (state)
            WR_IDLE, WR_WRITE: begin
               if (full) begin
                  wr_ptr_nxt = wr_commit;
                  if (s_axis_tlast) begin
                     inc_ovf   = 1'b1;
                     state_nxt = WR_IDLE;
                  end else begin
                     state_nxt = WR_DROP;
                  end
               end else begin
                  ram_we     = 1'b1;
                  wr_ptr_nxt = wr_ptr + 1'b1;
                  if (s_axis_tlast) begin
                     state_nxt = WR_IDLE;
                     if (s_axis_tuser) begin
                        wr_ptr_nxt = wr_commit;
                        inc_err    = 1'b1;
                     end else begin
                        wr_commit_nxt = wr_ptr + 1'b1;
                        inc_fwd       = 1'b1;
                     end
                  end else begin
                     state_nxt = WR_WRITE;
                  end
               end
            end
            WR_DROP: begin
               if (s_axis_tlast) begin
                  inc_ovf   = 1'b1;
                  state_nxt = WR_IDLE;
               end
            end
            default: state_nxt = WR_IDLE;
         endcase
      end
   end

   assign readable = fetch_ptr != wr_commit;
   assign consume  = m_axis_tvalid && m_axis_tready;
   assign fetch    = readable && (!m_axis_tvalid || consume || !q_valid);

   always_ff @(posedge clk156 or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr        <= '0;
         wr_commit     <= '0;
         rd_ptr        <= '0;
         fetch_ptr     <= '0;
         q_valid       <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tlast  <= 1'b0;
         pkt_fwd_cnt   <= '0;
         drop_err_cnt  <= '0;
         drop_ovf_cnt  <= '0;
      end else begin
         wr_ptr    <= wr_ptr_nxt;
         wr_commit <= wr_commit_nxt;
         if (fetch)
            fetch_ptr <= fetch_ptr + 1'b1;
         if (consume)
            rd_ptr <= rd_ptr + 1'b1;
         // skid word moves into the output register whenever that register frees up
         if (q_valid && (!m_axis_tvalid || consume)) begin
            m_axis_tvalid <= 1'b1;
            {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= ram_q;
         end else if (consume) begin
            m_axis_tvalid <= 1'b0;
         end
         if (fetch)
            q_valid <= 1'b1;
         else if (!m_axis_tvalid || consume)
            q_valid <= 1'b0;
         if (inc_fwd)
            pkt_fwd_cnt <= pkt_fwd_cnt + 1'b1;
         if (inc_err)
            drop_err_cnt <= drop_err_cnt + 1'b1;
         if (inc_ovf)
            drop_ovf_cnt <= drop_ovf_cnt + 1'b1;
      end
   end

   assign m_axis_tuser = 1'b0;
   assign fifo_level   = wr_ptr - rd_ptr;

   eth_pkt_fifo_ram #(
      .ADDR_W (DEPTH_LOG2),
      .DATA_W (FIFO_WORD_W)
   ) u_ram (
      .clk156  (clk156),
      .wr_en   (ram_we),
      .wr_addr (wr_ptr[DEPTH_LOG2-1:0]),
      .wr_data ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
      .rd_en   (fetch),
      .rd_addr (fetch_ptr[DEPTH_LOG2-1:0]),
      .rd_data (ram_q)
   );
endmodule
